// File: rtl/lidar_feature_quantizer_if.sv
// Handshake bundle between the cluster feature extractor, the quantizer and the fusion input FIFO.
// The master modport drives the input side and sinks the output; the slave modport is the quantizer.
interface lidar_feature_quantizer_if #(
  parameter int NUM_FEAT = 8,
  parameter int IN_W     = 32,
  parameter int OUT_W    = 16,
  parameter int TAG_W    = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_FEAT*IN_W-1:0]  in_feat;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_FEAT*OUT_W-1:0] out_vector;
  logic [TAG_W-1:0]          out_tag;
  logic                      out_last;
  logic [NUM_FEAT-1:0]       out_sat_mask;

  modport master (
    output in_valid, in_feat, in_last, out_ready,
    input  in_ready, out_valid, out_vector, out_tag, out_last, out_sat_mask
  );

  modport slave (
    input  in_valid, in_feat, in_last, out_ready,
    output in_ready, out_valid, out_vector, out_tag, out_last, out_sat_mask
  );
endinterface

// File: rtl/lidar_feature_quantizer.sv
// Two-stage clip / shift / saturate encoder for LiDAR cluster feature vectors, tagged per object.
// Optional LIDAR_FEAT_STATS_EN adds saturation-event and frame counters on the output side.
module lidar_feature_quantizer #(
  parameter int                  NUM_FEAT  = 8,
  parameter int                  IN_W      = 32,
  parameter int                  OUT_W     = 16,
  parameter int                  SHIFT     = 12,
  parameter logic [NUM_FEAT-1:0] CLIP_MASK = 8'hB8,
  parameter int                  TAG_W     = 8
) (
  input  logic clk,
  input  logic reset_n,
  lidar_feature_quantizer_if.slave bus
`ifdef LIDAR_FEAT_STATS_EN
  ,
  output logic [15:0] sat_events,
  output logic [15:0] frame_count
`endif
);

  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Stage 1: clipped features, indexed by feature number
  logic                          s1_valid_q, s1_valid_d;
  logic [NUM_FEAT-1:0][IN_W-1:0] s1_feat_q,  s1_feat_d;
  logic [TAG_W-1:0]              s1_tag_q,   s1_tag_d;
  logic                          s1_last_q,  s1_last_d;

  // Stage 2: output register
  logic                          s2_valid_q, s2_valid_d;
  logic [NUM_FEAT*OUT_W-1:0]     s2_vec_q,   s2_vec_d;
  logic [TAG_W-1:0]              s2_tag_q,   s2_tag_d;
  logic                          s2_last_q,  s2_last_d;
  logic [NUM_FEAT-1:0]           s2_sat_q,   s2_sat_d;

  logic [TAG_W-1:0]              tag_cnt_q,  tag_cnt_d;

  logic                          s2_load;
  logic                          s1_ready;
  logic                          in_fire;
  logic [NUM_FEAT*OUT_W-1:0]     q_vec;
  logic [NUM_FEAT-1:0]           q_sat;
  logic [IN_W-1:0]               raw_feat;
  logic signed [IN_W-1:0]        shifted;
  logic [IN_W-OUT_W:0]           upper;

  always_comb begin
    s2_load  = !s2_valid_q || bus.out_ready;
    s1_ready = !s1_valid_q || s2_load;
    in_fire  = bus.in_valid && s1_ready;
  end

  // Negative features on clip-enabled lanes are forced to zero before scaling.
  always_comb begin
    s1_valid_d = in_fire || (s1_valid_q && !s2_load);
    s1_feat_d  = s1_feat_q;
    s1_tag_d   = s1_tag_q;
    s1_last_d  = s1_last_q;
    tag_cnt_d  = tag_cnt_q;
    raw_feat   = '0;
    if (in_fire) begin
      for (int i = 0; i < NUM_FEAT; i++) begin
        raw_feat     = bus.in_feat[(NUM_FEAT-i)*IN_W-1 -: IN_W];
        s1_feat_d[i] = (CLIP_MASK[i] && raw_feat[IN_W-1]) ? '0 : raw_feat;
      end
      s1_tag_d  = tag_cnt_q;
      s1_last_d = bus.in_last;
      tag_cnt_d = bus.in_last ? '0 : tag_cnt_q + TAG_W'(1);
    end
  end

  // A shifted value fits in OUT_W bits iff its bits above OUT_W-2 are all sign copies.
  // out_sat_mask follows out_vector ordering: feature 0 in the MSB.
  always_comb begin
    q_vec   = '0;
    q_sat   = '0;
    shifted = '0;
    upper   = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      shifted = $signed(s1_feat_q[i]) >>> SHIFT;
      upper   = shifted[IN_W-1:OUT_W-1];
      if ((&upper) || !(|upper)) begin
        q_vec[(NUM_FEAT-i)*OUT_W-1 -: OUT_W] = shifted[OUT_W-1:0];
      end else begin
        q_vec[(NUM_FEAT-i)*OUT_W-1 -: OUT_W] = shifted[IN_W-1] ? OUT_MIN : OUT_MAX;
        q_sat[NUM_FEAT-1-i]                  = 1'b1;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s2_vec_d   = s2_vec_q;
    s2_tag_d   = s2_tag_q;
    s2_last_d  = s2_last_q;
    s2_sat_d   = s2_sat_q;
    if (s2_load && s1_valid_q) begin
      s2_vec_d  = q_vec;
      s2_tag_d  = s1_tag_q;
      s2_last_d = s1_last_q;
      s2_sat_d  = q_sat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_feat_q  <= '0;
      s1_tag_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_vec_q   <= '0;
      s2_tag_q   <= '0;
      s2_last_q  <= 1'b0;
      s2_sat_q   <= '0;
      tag_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_feat_q  <= s1_feat_d;
      s1_tag_q   <= s1_tag_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_vec_q   <= s2_vec_d;
      s2_tag_q   <= s2_tag_d;
      s2_last_q  <= s2_last_d;
      s2_sat_q   <= s2_sat_d;
      tag_cnt_q  <= tag_cnt_d;
    end
  end

  assign bus.in_ready     = s1_ready;
  assign bus.out_valid    = s2_valid_q;
  assign bus.out_vector   = s2_vec_q;
  assign bus.out_tag      = s2_tag_q;
  assign bus.out_last     = s2_last_q;
  assign bus.out_sat_mask = s2_sat_q;

`ifdef LIDAR_FEAT_STATS_EN
  logic        out_fire;
  logic [15:0] sat_events_q,  sat_events_d;
  logic [15:0] frame_count_q, frame_count_d;

  // Saturation counter sticks at all-ones; frame counter wraps.
  always_comb begin
    out_fire      = s2_valid_q && bus.out_ready;
    sat_events_d  = sat_events_q;
    frame_count_d = frame_count_q;
    if (out_fire && (|s2_sat_q) && (sat_events_q != 16'hFFFF)) begin
      sat_events_d = sat_events_q + 16'd1;
    end
    if (out_fire && s2_last_q) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_events_q  <= '0;
      frame_count_q <= '0;
    end else begin
      sat_events_q  <= sat_events_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign sat_events  = sat_events_q;
  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_lidar_feature_quantizer.sv
// Directed bench for lidar_feature_quantizer: vector table plus stall, last-of-frame and reset sequences.
module tb_lidar_feature_quantizer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lidar_feature_quantizer_if #(.NUM_FEAT(8), .IN_W(32), .OUT_W(16), .TAG_W(8)) bus ();

`ifdef LIDAR_FEAT_STATS_EN
  logic [15:0] sat_events;
  logic [15:0] frame_count;
`endif

  lidar_feature_quantizer #(
    .NUM_FEAT(8), .IN_W(32), .OUT_W(16), .SHIFT(12), .CLIP_MASK(8'hB8), .TAG_W(8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus)
`ifdef LIDAR_FEAT_STATS_EN
    ,
    .sat_events  (sat_events),
    .frame_count (frame_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] put32(input logic [255:0] base, input int idx, input logic [31:0] v);
    logic [255:0] r;
    r = base;
    r[(8-idx)*32-1 -: 32] = v;
    return r;
  endfunction

  function automatic logic [127:0] put16(input logic [127:0] base, input int idx, input logic [15:0] v);
    logic [127:0] r;
    r = base;
    r[(8-idx)*16-1 -: 16] = v;
    return r;
  endfunction

  typedef struct {
    logic [255:0] feat;
    logic [127:0] vec;
    logic [7:0]   sat;
  } vec_t;

  typedef struct {
    logic [127:0] vec;
    logic [7:0]   tag;
    logic         last;
  } exp_t;

  vec_t tbl[6];
  exp_t sb[$];
  logic [7:0] model_tag;

  // Stream vector k: feature 0 = (k+1)<<16, feature 6 = -((k+1)<<12), feature 7 = -1 (clipped).
  function automatic logic [255:0] stream_feat(input int k);
    logic [255:0] f;
    f = '0;
    f = put32(f, 0, 32'((k + 1) << 16));
    f = put32(f, 6, 32'(-((k + 1) << 12)));
    f = put32(f, 7, 32'hFFFF_FFFF);
    return f;
  endfunction

  function automatic logic [127:0] stream_vec(input int k);
    logic [127:0] v;
    v = '0;
    v = put16(v, 0, 16'((k + 1) << 4));
    v = put16(v, 6, 16'(-(k + 1)));
    return v;
  endfunction

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_feat   = '0;
    bus.out_ready = 1'b1;
    reset_n       = 1'b0;
    repeat (2) @(negedge clk);
    reset_n   = 1'b1;
    model_tag = '0;
  endtask

  task automatic stream(input int n, input int last_at, input int st_lo, input int st_hi, input string nm);
    int           sent = 0;
    int           rcvd = 0;
    bit           have_snap = 0;
    logic [127:0] snap_vec;
    logic [7:0]   snap_tag;
    exp_t         e;
    sb.delete();
    for (int c = 0; c < 80 && rcvd < n; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= st_lo && c < st_hi);
      bus.in_valid  = (sent < n);
      bus.in_feat   = stream_feat(sent);
      bus.in_last   = (sent == last_at);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        if (!have_snap) begin
          have_snap = 1;
          snap_vec  = bus.out_vector;
          snap_tag  = bus.out_tag;
        end else begin
          chk({nm, "_stall_vec"}, bus.out_vector, snap_vec);
          chk({nm, "_stall_tag"}, bus.out_tag, snap_tag);
        end
      end else begin
        have_snap = 0;
      end
      if (c > st_lo && c < st_hi && sent < n) chk({nm, "_in_ready_low"}, bus.in_ready, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk({nm, "_unexpected_out"}, 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk({nm, "_vec"}, bus.out_vector, e.vec);
          chk({nm, "_tag"}, bus.out_tag, e.tag);
          chk({nm, "_last"}, bus.out_last, e.last);
          chk({nm, "_sat"}, bus.out_sat_mask, 8'h00);
        end
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) begin
        e.vec  = stream_vec(sent);
        e.tag  = model_tag;
        e.last = (sent == last_at);
        sb.push_back(e);
        model_tag = e.last ? 8'd0 : model_tag + 8'd1;
        sent++;
      end else if (bus.in_valid) begin
        bus.in_feat = {8{32'hDEAD_BEEF}};
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    chk({nm, "_count"}, 128'(rcvd), 128'(n));
  endtask

  initial begin
    logic [255:0] f;
    logic [127:0] v;
    int           nsat;

    // Single-vector table, out_ready held high.
    f = put32('0, 0, 32'h0180_0000);
    tbl[0] = '{f, put16('0, 0, 16'h1800), 8'h00};
    f = put32(put32('0, 0, 32'hFF00_0000), 3, 32'hFF00_0000);
    tbl[1] = '{f, put16('0, 0, 16'hF000), 8'h00};
    f = put32(put32('0, 1, 32'h0A00_0000), 2, 32'hF600_0000);
    tbl[2] = '{f, put16(put16('0, 1, 16'h7FFF), 2, 16'h8000), 8'b0110_0000};
    f = {8{32'h8000_0000}};
    v = put16(put16(put16(put16('0, 0, 16'h8000), 1, 16'h8000), 2, 16'h8000), 6, 16'h8000);
    tbl[3] = '{f, v, 8'b1110_0010};
    f = put32(put32(put32('0, 0, 32'h07FF_F000), 1, 32'h0800_0000), 2, 32'hF800_0000);
    f = put32(put32(put32(f, 4, 32'h0000_0FFF), 6, 32'hFFFF_FFFF), 7, 32'hFFFF_FFFF);
    v = put16(put16(put16(put16('0, 0, 16'h7FFF), 1, 16'h7FFF), 2, 16'h8000), 6, 16'hFFFF);
    tbl[4] = '{f, v, 8'b0100_0000};
    f = put32('0, 5, 32'h7FFF_FFFF);
    tbl[5] = '{f, put16('0, 5, 16'h7FFF), 8'b0000_0100};

    do_reset();
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_vector", bus.out_vector, 128'h0);
    chk("rst_out_tag", bus.out_tag, 8'h00);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_sat_mask", bus.out_sat_mask, 8'h00);

    nsat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_feat  = tbl[i].feat;
      bus.in_last  = 1'b0;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), bus.in_ready, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      chk($sformatf("tbl%0d_not_yet", i), bus.out_valid, 1'b0);
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("tbl%0d_vec", i), bus.out_vector, tbl[i].vec);
      chk($sformatf("tbl%0d_sat", i), bus.out_sat_mask, tbl[i].sat);
      chk($sformatf("tbl%0d_tag", i), bus.out_tag, 8'(i));
      if (tbl[i].sat != 0) nsat++;
    end
    @(negedge clk);
    #1;
    chk("tbl_drained", bus.out_valid, 1'b0);
`ifdef LIDAR_FEAT_STATS_EN
    chk("stats_sat_events", sat_events, 128'(nsat));
`endif

    // Two vectors held with out_ready low, then reset mid-stream.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_feat   = tbl[0].feat;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_held", bus.out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_vector", bus.out_vector, 128'h0);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    model_tag     = '0;

    stream(5, -1, 3, 7, "stall");

    do_reset();
    stream(5, 2, 0, 0, "frame");
    @(negedge clk);
`ifdef LIDAR_FEAT_STATS_EN
    chk("stats_frame_count", frame_count, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
